// File: rtl/clock_set_editor_if.sv
// Front-panel editor bus: raw keys and live clock values in, edited values and commit strobes out.
// Latency: wiring only, no storage.
// Backpressure: none; load strobes are single-cycle and must be taken when seen.
interface clock_set_editor_if;
    logic        sw_mode;
    logic        tick_1s;
    logic        butt_change;
    logic        butt_increase;
    logic        butt_decrease;
    logic [23:0] cur_time;
    logic [31:0] cur_date;
    logic [23:0] set_time;
    logic [31:0] set_date;
    logic        load_time;
    logic        load_date;
    logic        edit_active;
    logic [7:0]  blink_mask;

    // Panel / clock side
    modport master (
        output sw_mode, tick_1s, butt_change, butt_increase, butt_decrease, cur_time, cur_date,
        input  set_time, set_date, load_time, load_date, edit_active, blink_mask
    );

    // Editor side
    modport slave (
        input  sw_mode, tick_1s, butt_change, butt_increase, butt_decrease, cur_time, cur_date,
        output set_time, set_date, load_time, load_date, edit_active, blink_mask
    );
endinterface

// File: rtl/clock_set_editor.sv
// Front-panel time/date editor: debounced keys drive a field FSM over a BCD shadow, committed by a load strobe.
// Latency: key press event DEBOUNCE_CYCLES+3 cycles after raw edge; edit lands one cycle after the event.
// Backpressure: none; commit is a single-cycle strobe. Optional idle abort via macro EDIT_TIMEOUT_EN.
module clock_set_editor #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_HALF      = 12_500_000,
    parameter int unsigned TIMEOUT_S       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    clock_set_editor_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BKW = $clog2(BLINK_HALF + 1);

    typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_F2, S_COMMIT} state_t;

    // ---------------- BCD helpers ----------------
    // Two-digit BCD step with wrap between lo and hi (out-of-range values wrap too)
    function automatic logic [7:0] bcd2_step(input logic [7:0] v, input logic up,
                                             input logic [7:0] lo, input logic [7:0] hi);
        logic [7:0] r;
        if (up) begin
            if (v >= hi)              r = lo;
            else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
            else                      r = v + 8'd1;
        end else begin
            if (v <= lo)              r = hi;
            else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
            else                      r = v - 8'd1;
        end
        return r;
    endfunction

    // Four-digit BCD step; the digit carry chain wraps 9999<->0000 naturally
    function automatic logic [15:0] bcd4_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (up) begin
                    if (r[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
                    else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                    else begin
                        r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Two BCD digits divisible by 4: (10t+o) mod 4 == (2*t[0] + o) mod 4
    function automatic logic bcd_div4(input logic [3:0] t, input logic [3:0] o);
        logic [1:0] s;
        s = {t[0], 1'b0} + o[1:0];
        return (s == 2'd0);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] mo, input logic [15:0] yr);
        logic leap;
        logic [7:0] r;
        leap = bcd_div4(yr[7:4], yr[3:0]) && ((yr[7:0] != 8'h00) || bcd_div4(yr[15:12], yr[11:8]));
        case (mo)
            8'h02:                      r = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    // ---------------- key conditioning ----------------
    logic [2:0]     w_raw;
    logic [2:0]     r_sync1, r_sync2, r_deb, r_deb_q, r_press;
    logic [DBW-1:0] r_db_cnt [3];
    logic           w_chg, w_inc, w_dec, w_any_key;

    assign w_raw = {bus.butt_decrease, bus.butt_increase, bus.butt_change};

    // Synchronise raw keys, accept a new level after DEBOUNCE_CYCLES stable samples, pulse on release->press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_deb_q <= '1;
            r_press <= '0;
            for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= r_deb;
            r_press <= r_deb_q & ~r_deb;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[k]    <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DBW'(1);
                end
            end
        end
    end

    // inc and dec together cancel each other
    assign w_chg     = r_press[0];
    assign w_inc     = r_press[1] & ~r_press[2];
    assign w_dec     = r_press[2] & ~r_press[1];
    assign w_any_key = |r_press;

    // ---------------- FSM and shadow ----------------
    state_t      r_state, w_next_state;
    logic [23:0] r_time;
    logic [31:0] r_date;
    logic        r_mode;
    logic        r_blink_ph;
    logic [BKW-1:0] r_blink_cnt;
    logic        w_capture, w_field_entry, w_step_up, w_step_dn, w_clamp;
    logic        w_load_time, w_load_date;
    logic [7:0]  w_field_mask, w_blink_mask;
    logic [7:0]  w_dim;
    logic        w_timeout;

    assign w_dim = days_in_month(r_date[23:16], r_date[15:0]);

`ifdef EDIT_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_S + 1);
    logic [TOW-1:0] r_to_cnt;
    logic           w_in_field;

    assign w_in_field = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_F2);
    assign w_timeout  = w_in_field && bus.tick_1s && !w_any_key && (r_to_cnt == TOW'(TIMEOUT_S - 1));

    // Count idle seconds while a field is open; any key event restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_to_cnt <= '0;
        else if (!w_in_field || w_any_key) r_to_cnt <= '0;
        else if (bus.tick_1s)             r_to_cnt <= r_to_cnt + TOW'(1);
    end
`else
    logic w_unused_tick;
    assign w_timeout     = 1'b0;
    assign w_unused_tick = bus.tick_1s ^ (TIMEOUT_S == 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next state, datapath controls, commit strobes and blink mask
    always_comb begin
        w_next_state  = r_state;
        w_capture     = 1'b0;
        w_field_entry = 1'b0;
        w_step_up     = 1'b0;
        w_step_dn     = 1'b0;
        w_clamp       = 1'b0;
        w_load_time   = 1'b0;
        w_load_date   = 1'b0;
        w_field_mask  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_chg) begin
                    w_next_state  = S_F0;
                    w_capture     = 1'b1;
                    w_field_entry = 1'b1;
                end
            end
            S_F0, S_F1, S_F2: begin
                if (r_state == S_F0)      w_field_mask = 8'hC0;
                else if (r_state == S_F1) w_field_mask = 8'h30;
                else                      w_field_mask = r_mode ? 8'h0F : 8'h0C;
                // A mode flip or idle timeout abandons the edit without committing
                if ((bus.sw_mode != r_mode) || w_timeout) begin
                    w_next_state = S_IDLE;
                end else if (w_chg) begin
                    w_field_entry = 1'b1;
                    if (r_state == S_F0)      w_next_state = S_F1;
                    else if (r_state == S_F1) w_next_state = S_F2;
                    else begin
                        w_next_state = S_COMMIT;
                        w_clamp      = 1'b1;
                    end
                end else begin
                    w_step_up = w_inc;
                    w_step_dn = w_dec;
                end
            end
            S_COMMIT: begin
                w_load_time  = ~r_mode;
                w_load_date  = r_mode;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        w_blink_mask = r_blink_ph ? w_field_mask : 8'h00;
    end

    // Shadow copy: capture on entry, clamp the day on commit, otherwise step the open field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time <= 24'h000000;
            r_date <= 32'h0101_2024;
            r_mode <= 1'b0;
        end else if (w_capture) begin
            r_time <= bus.cur_time;
            r_date <= bus.cur_date;
            r_mode <= bus.sw_mode;
        end else if (w_clamp) begin
            if (r_mode && (r_date[31:24] > w_dim)) r_date[31:24] <= w_dim;
        end else if (w_step_up || w_step_dn) begin
            case (r_state)
                S_F0: if (r_mode) r_date[31:24] <= bcd2_step(r_date[31:24], w_step_up, 8'h01, 8'h31);
                      else        r_time[23:16] <= bcd2_step(r_time[23:16], w_step_up, 8'h00, 8'h23);
                S_F1: if (r_mode) r_date[23:16] <= bcd2_step(r_date[23:16], w_step_up, 8'h01, 8'h12);
                      else        r_time[15:8]  <= bcd2_step(r_time[15:8],  w_step_up, 8'h00, 8'h59);
                S_F2: if (r_mode) r_date[15:0]  <= bcd4_step(r_date[15:0], w_step_up);
                      else        r_time[7:0]   <= bcd2_step(r_time[7:0],   w_step_up, 8'h00, 8'h59);
                default: ;
            endcase
        end
    end

    // Blink phase generator; restarts on every field entry so the new field is shown first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (w_field_entry) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == BKW'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + BKW'(1);
        end
    end

    assign bus.set_time    = r_time;
    assign bus.set_date    = r_date;
    assign bus.load_time   = w_load_time;
    assign bus.load_date   = w_load_date;
    assign bus.edit_active = (r_state != S_IDLE);
    assign bus.blink_mask  = w_blink_mask;
endmodule

// File: tb/tb_clock_set_editor.sv
// Self-checking bench for clock_set_editor: vector table, corner sequences, randomized edits vs a reference model.
// Latency: key presses held long enough for debounce plus pipeline.
// Backpressure: n/a; every wait is bounded.
module tb_clock_set_editor;
    localparam int DEB = 4;
    localparam int BLK = 8;
    localparam int TOS = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_set_editor_if bus();

    clock_set_editor #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_HALF     (BLK),
        .TIMEOUT_S      (TOS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_lt  = 0;
    int n_ld  = 0;
    logic [23:0] cap_t;
    logic [31:0] cap_d;

    typedef struct {
        logic        mode;
        logic [23:0] ct;
        logic [31:0] cd;
        int          d0, d1, d2;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    // Strobe monitor
    always @(negedge clk) begin
        if (bus.load_time) begin n_lt++; cap_t = bus.set_time; end
        if (bus.load_date) begin n_ld++; cap_d = bus.set_date; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic press(input logic c, input logic i, input logic d);
        @(negedge clk);
        bus.butt_change   = ~c;
        bus.butt_increase = ~i;
        bus.butt_decrease = ~d;
        repeat (DEB + 7) @(negedge clk);
        bus.butt_change   = 1'b1;
        bus.butt_increase = 1'b1;
        bus.butt_decrease = 1'b1;
        repeat (DEB + 7) @(negedge clk);
    endtask

    task automatic wait_edit(input logic lvl, input int budget, input string name);
        int n = 0;
        while (bus.edit_active !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, bus.edit_active}, {31'd0, lvl});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    function automatic int b2i2(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction
    function automatic int b2i4(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction
    function automatic logic [7:0] i2b2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction
    function automatic logic [15:0] i2b4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    function automatic int wrap(input int x, input int lo, input int n);
        return ((x - lo) % n + n) % n + lo;
    endfunction

    function automatic logic [31:0] ref_edit(input logic mode, input logic [23:0] ct, input logic [31:0] cd,
                                             input int d0, input int d1, input int d2);
        int a, b, c, dim;
        bit leap;
        if (!mode) begin
            a = wrap(b2i2(ct[23:16]) + d0, 0, 24);
            b = wrap(b2i2(ct[15:8])  + d1, 0, 60);
            c = wrap(b2i2(ct[7:0])   + d2, 0, 60);
            return {8'h00, i2b2(a), i2b2(b), i2b2(c)};
        end
        a = wrap(b2i2(cd[31:24]) + d0, 1, 31);
        b = wrap(b2i2(cd[23:16]) + d1, 1, 12);
        c = wrap(b2i4(cd[15:0])  + d2, 0, 10000);
        leap = (c % 4 == 0) && ((c % 100 != 0) || (c % 400 == 0));
        if (b == 2)                                       dim = leap ? 29 : 28;
        else if (b == 4 || b == 6 || b == 9 || b == 11)   dim = 30;
        else                                              dim = 31;
        if (a > dim) a = dim;
        return {i2b2(a), i2b2(b), i2b4(c)};
    endfunction

    // Full edit pass: enter, step each field by a signed count, commit
    task automatic run_edit(input logic mode, input logic [23:0] ct, input logic [31:0] cd,
                            input int d0, input int d1, input int d2, input string tag,
                            input logic [31:0] exp);
        int ds[3];
        int n;
        ds = '{d0, d1, d2};
        @(negedge clk);
        bus.sw_mode  = mode;
        bus.cur_time = ct;
        bus.cur_date = cd;
        n_lt  = 0;
        n_ld  = 0;
        cap_t = 'x;
        cap_d = 'x;
        press(1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            n = (ds[f] < 0) ? -ds[f] : ds[f];
            for (int k = 0; k < n; k++) press(1'b0, ds[f] > 0, ds[f] < 0);
            press(1'b1, 1'b0, 1'b0);
        end
        repeat (4) @(negedge clk);
        chk({tag, "_idle_after"}, {31'd0, bus.edit_active}, 32'd0);
        if (mode) begin
            chk({tag, "_load_date_cnt"}, n_ld, 1);
            chk({tag, "_load_time_cnt"}, n_lt, 0);
            chk({tag, "_set_date"}, cap_d, exp);
        end else begin
            chk({tag, "_load_time_cnt"}, n_lt, 1);
            chk({tag, "_load_date_cnt"}, n_ld, 0);
            chk({tag, "_set_time"}, {8'h00, cap_t}, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int saw_on, saw_bad;
        bus.sw_mode       = 1'b0;
        bus.tick_1s       = 1'b0;
        bus.butt_change   = 1'b1;
        bus.butt_increase = 1'b1;
        bus.butt_decrease = 1'b1;
        bus.cur_time      = 24'h000000;
        bus.cur_date      = 32'h01012024;

        vecs[0] = '{1'b0, 24'h235930, 32'h01012024,  1, -1,  0, 32'h00005830};
        vecs[1] = '{1'b1, 24'h000000, 32'h31012023,  0,  1,  0, 32'h28022023};
        vecs[2] = '{1'b1, 24'h000000, 32'h31012024,  0,  1,  0, 32'h29022024};
        vecs[3] = '{1'b1, 24'h000000, 32'h31012100,  0,  1,  0, 32'h28022100};
        vecs[4] = '{1'b1, 24'h000000, 32'h31012000,  0,  1,  0, 32'h29022000};
        vecs[5] = '{1'b0, 24'h000000, 32'h01012024, -1, -1, -1, 32'h00235959};
        vecs[6] = '{1'b1, 24'h000000, 32'h01129999, -1,  1,  1, 32'h31010000};
        vecs[7] = '{1'b1, 24'h000000, 32'h31032023,  0,  1,  0, 32'h30042023};

        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_set_time",  {8'h00, bus.set_time}, 32'h00000000);
        chk("rst_set_date",  bus.set_date, 32'h01012024);
        chk("rst_load_time", {31'd0, bus.load_time}, 32'd0);
        chk("rst_load_date", {31'd0, bus.load_date}, 32'd0);
        chk("rst_edit",      {31'd0, bus.edit_active}, 32'd0);
        chk("rst_mask",      {24'd0, bus.blink_mask}, 32'd0);

        // inc in IDLE is ignored
        bus.cur_time = 24'h111111;
        n_lt = 0;
        press(1'b0, 1'b1, 1'b0);
        chk("idle_inc_edit", {31'd0, bus.edit_active}, 32'd0);
        chk("idle_inc_shadow", {8'h00, bus.set_time}, 32'h00000000);

        // Table-driven full edits
        for (int v = 0; v < 8; v++)
            run_edit(vecs[v].mode, vecs[v].ct, vecs[v].cd, vecs[v].d0, vecs[v].d1, vecs[v].d2,
                     $sformatf("vec%0d", v), vecs[v].exp);

        // Time F0: blink starts visible, then flashes hour digits; bounce and inc+dec ignored
        @(negedge clk);
        bus.sw_mode  = 1'b0;
        bus.cur_time = 24'h123456;
        n_lt = 0; n_ld = 0;
        bus.butt_change = 1'b0;
        wait_edit(1'b1, 4 * DEB + 20, "enter_f0");
        chk("blink_first_visible", {24'd0, bus.blink_mask}, 32'd0);
        saw_on = 0; saw_bad = 0;
        for (int c = 0; c < 3 * BLK; c++) begin
            @(negedge clk);
            if (bus.blink_mask == 8'hC0) saw_on = 1;
            else if (bus.blink_mask != 8'h00) saw_bad++;
        end
        chk("blink_time_f0_on", saw_on, 1);
        chk("blink_time_f0_bad", saw_bad, 0);
        bus.butt_change = 1'b1;
        repeat (DEB + 7) @(negedge clk);
        bus.butt_increase = 1'b0;
        repeat (3) @(negedge clk);
        bus.butt_increase = 1'b1;
        repeat (2 * DEB + 8) @(negedge clk);
        chk("bounce_no_edit", {8'h00, bus.set_time}, 32'h00123456);
        press(1'b0, 1'b1, 1'b1);
        chk("inc_dec_cancel", {8'h00, bus.set_time}, 32'h00123456);
        press(1'b1, 1'b1, 1'b0);
        chk("chg_wins_over_inc", {8'h00, bus.set_time}, 32'h00123456);
        chk("chg_wins_still_edit", {31'd0, bus.edit_active}, 32'd1);
        // Mode flip in F1 aborts next cycle without commit
        @(negedge clk);
        bus.sw_mode = 1'b1;
        @(negedge clk);
        chk("mode_flip_abort", {31'd0, bus.edit_active}, 32'd0);
        repeat (4) @(negedge clk);
        chk("mode_flip_no_load", n_lt + n_ld, 0);

        // Date F2 blinks all four year digits
        bus.cur_date = 32'h15062023;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        saw_on = 0; saw_bad = 0;
        for (int c = 0; c < 3 * BLK; c++) begin
            @(negedge clk);
            if (bus.blink_mask == 8'h0F) saw_on = 1;
            else if (bus.blink_mask != 8'h00) saw_bad++;
        end
        chk("blink_date_f2_on", saw_on, 1);
        chk("blink_date_f2_bad", saw_bad, 0);
        @(negedge clk);
        bus.sw_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("date_abort_no_load", n_lt + n_ld, 0);

        // Reset asserted mid-F1
        bus.cur_time = 24'h235930;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("pre_reset_edit", {31'd0, bus.edit_active}, 32'd1);
        chk("pre_reset_shadow", {8'h00, bus.set_time}, 32'h00005930);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_edit",      {31'd0, bus.edit_active}, 32'd0);
        chk("midrst_set_time",  {8'h00, bus.set_time}, 32'h00000000);
        chk("midrst_set_date",  bus.set_date, 32'h01012024);
        chk("midrst_mask",      {24'd0, bus.blink_mask}, 32'd0);
        chk("midrst_loads",     {30'd0, bus.load_time, bus.load_date}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_strobe", n_lt + n_ld, 0);

        // Idle timeout in F0
        press(1'b1, 1'b0, 1'b0);
        for (int t = 0; t < TOS; t++) begin
            @(negedge clk); bus.tick_1s = 1'b1;
            @(negedge clk); bus.tick_1s = 1'b0;
            repeat (3) @(negedge clk);
        end
`ifdef EDIT_TIMEOUT_EN
        chk("timeout_abort", {31'd0, bus.edit_active}, 32'd0);
`else
        chk("timeout_stays", {31'd0, bus.edit_active}, 32'd1);
`endif
        chk("timeout_no_load", n_lt + n_ld, 0);
        do_reset();

        // Randomized edits against the reference model
        for (int r = 0; r < 12; r++) begin
            logic m;
            logic [23:0] ct;
            logic [31:0] cd;
            int d0, d1, d2;
            m  = 1'($urandom_range(0, 1));
            ct = {i2b2(int'($urandom_range(0, 23))), i2b2(int'($urandom_range(0, 59))),
                  i2b2(int'($urandom_range(0, 59)))};
            cd = {i2b2(int'($urandom_range(1, 31))), i2b2(int'($urandom_range(1, 12))),
                  i2b4(int'($urandom_range(0, 9999)))};
            d0 = int'($urandom_range(0, 6)) - 3;
            d1 = int'($urandom_range(0, 6)) - 3;
            d2 = int'($urandom_range(0, 6)) - 3;
            run_edit(m, ct, cd, d0, d1, d2, $sformatf("rnd%0d", r), ref_edit(m, ct, cd, d0, d1, d2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
